// File: rtl/alu_hs_seq.sv
// Handshaked WIDTH-bit ALU using the 16-opcode map, with registered flags.
// Opcode F runs a multi-cycle restoring divider.
`timescale 1ns/1ps

module alu_hs_seq #(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [3:0]       Opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   Result,
    output logic [WIDTH-1:0] Remainder,
    output logic             Carry_Flag,
    output logic             Zero_Flag,
    output logic             DivZ_Flag
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, DIV, OUT} state_t;

    state_t           state;
    state_t           next_state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] divisor;
    logic             accept;
    logic             start_div;
    logic             load_fast;
    logic             load_div;
    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   b_ext;
    logic [WIDTH:0]   fast_result;
    logic [WIDTH-1:0] fast_rem;
    logic             fast_divz;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] sub;
    logic             fits;

    assign accept    = in_valid && in_ready;
    assign start_div = accept && (Opcode == 4'hF) && (op2 != '0);
    assign load_fast = accept && !start_div;
    assign a_ext     = {1'b0, op1};
    assign b_ext     = {1'b0, op2};

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_div) next_state = DIV;
            DIV:     if (count == CW'(WIDTH - 1)) next_state = OUT;
            OUT:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE) && (!out_valid || out_ready);
        load_div = (state == OUT);
    end

    always_comb begin
        fast_result = '0;
        fast_rem    = '0;
        fast_divz   = 1'b0;
        case (Opcode)
            4'h0: fast_result = a_ext - (WIDTH+1)'(1);
            4'h1: fast_result = a_ext >> 1;
            4'h2: fast_result = {op1, 1'b0};
            4'h3: fast_result = {1'b0, ~(op1 | op2)};
            4'h4: fast_result = {1'b0, ~(op1 & op2)};
            4'h5: fast_result = {1'b0, ~(op1 ^ op2)};
            4'h6: fast_result = {{WIDTH{1'b0}}, op1 == op2};
            4'h7: fast_result = {{WIDTH{1'b0}}, op1 < op2};
            4'h8: fast_result = {{WIDTH{1'b0}}, op1 > op2};
            4'h9: fast_result = {1'b0, op1 | op2};
            4'hA: fast_result = {1'b0, op1 & op2};
            4'hB: fast_result = {1'b0, op1 ^ op2};
            4'hC: fast_result = a_ext + (WIDTH+1)'(1);
            4'hD: fast_result = a_ext + b_ext;
            4'hE: fast_result = a_ext - b_ext;
            4'hF: begin
                fast_result = {1'b0, {WIDTH{1'b1}}};
                fast_rem    = op1;
                fast_divz   = 1'b1;
            end
            default: fast_result = '0;
        endcase
    end

    // One restoring step: bring in the next dividend bit, subtract if it fits.
    // The true difference is below 2^WIDTH, so the low bits suffice.
    assign shifted = {rem, quo[WIDTH-1]};
    assign fits    = (shifted >= {1'b0, divisor});
    assign sub     = shifted[WIDTH-1:0] - divisor;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            quo     <= '0;
            rem     <= '0;
            divisor <= '0;
            count   <= '0;
        end else if (start_div) begin
            quo     <= op1;
            rem     <= '0;
            divisor <= op2;
            count   <= '0;
        end else if (state == DIV) begin
            quo   <= {quo[WIDTH-2:0], fits};
            rem   <= fits ? sub : shifted[WIDTH-1:0];
            count <= count + CW'(1);
        end
    end

    // Outputs hold until popped; a same-edge 1-cycle load keeps out_valid high.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            out_valid  <= 1'b0;
            Result     <= '0;
            Remainder  <= '0;
            Carry_Flag <= 1'b0;
            Zero_Flag  <= 1'b0;
            DivZ_Flag  <= 1'b0;
        end else if (load_div) begin
            out_valid  <= 1'b1;
            Result     <= {1'b0, quo};
            Remainder  <= rem;
            Carry_Flag <= 1'b0;
            Zero_Flag  <= (quo == '0);
            DivZ_Flag  <= 1'b0;
        end else if (load_fast) begin
            out_valid  <= 1'b1;
            Result     <= fast_result;
            Remainder  <= fast_rem;
            Carry_Flag <= fast_result[WIDTH];
            Zero_Flag  <= (fast_result == '0);
            DivZ_Flag  <= fast_divz;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_hs_seq.sv
// Scoreboard bench for alu_hs_seq: directed cases plus randomized traffic,
// checked against an arithmetic reference model.
`timescale 1ns/1ps

module tb_alu_hs_seq;

    localparam int W    = 8;
    localparam int MODV = 1 << (W + 1);
    localparam int MSKW = (1 << W) - 1;

    typedef struct {
        int result;
        int rem;
        int carry;
        int zero;
        int divz;
    } exp_t;

    logic         Clock;
    logic         Resetn;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic [3:0]   Opcode;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   Result;
    logic [W-1:0] Remainder;
    logic         Carry_Flag;
    logic         Zero_Flag;
    logic         DivZ_Flag;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   pops   = 0;
    bit   stim_done;

    alu_hs_seq #(.WIDTH(W)) dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op1        (op1),
        .op2        (op2),
        .Opcode     (Opcode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Result     (Result),
        .Remainder  (Remainder),
        .Carry_Flag (Carry_Flag),
        .Zero_Flag  (Zero_Flag),
        .DivZ_Flag  (DivZ_Flag)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic exp_t model(input int a, input int b, input int op);
        exp_t e;
        e.rem  = 0;
        e.divz = 0;
        case (op)
            0:  e.result = (a - 1 + MODV) % MODV;
            1:  e.result = a / 2;
            2:  e.result = (a * 2) % MODV;
            3:  e.result = ~(a | b) & MSKW;
            4:  e.result = ~(a & b) & MSKW;
            5:  e.result = ~(a ^ b) & MSKW;
            6:  e.result = (a == b) ? 1 : 0;
            7:  e.result = (a < b) ? 1 : 0;
            8:  e.result = (a > b) ? 1 : 0;
            9:  e.result = a | b;
            10: e.result = a & b;
            11: e.result = a ^ b;
            12: e.result = (a + 1) % MODV;
            13: e.result = (a + b) % MODV;
            14: e.result = (a - b + MODV) % MODV;
            default: begin
                if (b == 0) begin
                    e.result = MSKW;
                    e.rem    = a;
                    e.divz   = 1;
                end else begin
                    e.result = a / b;
                    e.rem    = a % b;
                end
            end
        endcase
        e.carry = (e.result >= (1 << W)) ? 1 : 0;
        e.zero  = (e.result == 0) ? 1 : 0;
        return e;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Call just after a rising edge; returns just after the accepting edge.
    task automatic applyStimulus(input int a, input int b, input int op);
        bit ok = 0;
        in_valid = 1'b1;
        op1      = W'(a);
        op2      = W'(b);
        Opcode   = 4'(op);
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge Clock);
            if (in_ready) begin
                sb.push_back(model(a, b, op));
                ok = 1;
            end
            @(posedge Clock);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) checkOutput("accept_timeout", 0, 1);
    endtask

    task automatic waitDrain(input string name);
        out_ready = 1'b1;
        for (int i = 0; i < 500 && sb.size() != 0; i++) @(posedge Clock);
        checkOutput(name, sb.size(), 0);
        @(posedge Clock);
        #1;
    endtask

    // Monitor: a transfer happens on the next rising edge when valid && ready.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            if (Resetn && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_out_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    pops++;
                    checkOutput("result", int'(Result), e.result);
                    checkOutput("remainder", int'(Remainder), e.rem);
                    checkOutput("carry", int'(Carry_Flag), e.carry);
                    checkOutput("zero", int'(Zero_Flag), e.zero);
                    checkOutput("divz", int'(DivZ_Flag), e.divz);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int busy;
        int lat;
        int pops_before;
        int seen;

        Resetn    = 1'b0;
        in_valid  = 1'b0;
        op1       = '0;
        op2       = '0;
        Opcode    = '0;
        out_ready = 1'b1;
        stim_done = 1'b0;

        repeat (3) @(posedge Clock);
        @(negedge Clock);
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_result", int'(Result), 0);
        checkOutput("rst_remainder", int'(Remainder), 0);
        checkOutput("rst_flags", int'({Carry_Flag, Zero_Flag, DivZ_Flag}), 0);
        @(posedge Clock);
        #1;
        Resetn = 1'b1;
        @(negedge Clock);
        checkOutput("rst_in_ready", int'(in_ready), 1);
        @(posedge Clock);
        #1;

        $display("[TB] directed add / decrement / subtract");
        applyStimulus(8'hFF, 8'h01, 13);
        applyStimulus(8'h00, 8'h00, 0);
        applyStimulus(8'h5A, 8'h5A, 14);
        applyStimulus(8'h37, 8'h00, 15);
        waitDrain("drain_directed");

        $display("[TB] divide latency");
        applyStimulus(200, 7, 15);
        busy = 0;
        lat  = -1;
        for (int i = 0; i < 50 && lat < 0; i++) begin
            @(negedge Clock);
            if (out_valid) lat = i;
            else if (!in_ready) busy++;
            op1    = W'($urandom);
            op2    = W'($urandom);
            Opcode = 4'($urandom);
        end
        checkOutput("div_busy_cycles", busy, W + 1);
        checkOutput("div_latency_edges", lat, W + 1);
        @(posedge Clock);
        #1;
        waitDrain("drain_div");

        $display("[TB] backpressure");
        out_ready   = 1'b0;
        pops_before = pops;
        fork
            begin
                applyStimulus(8'h10, 8'h20, 13);
                applyStimulus(8'h33, 8'h0F, 11);
                applyStimulus(8'h80, 8'h00, 2);
            end
            begin
                seen = 0;
                for (int i = 0; i < 50 && !seen; i++) begin
                    @(negedge Clock);
                    if (out_valid) seen = 1;
                end
                checkOutput("bp_out_valid", seen, 1);
                for (int i = 0; i < 6; i++) begin
                    @(negedge Clock);
                    checkOutput("bp_held_result", int'(Result), 'h30);
                    checkOutput("bp_in_ready", int'(in_ready), 0);
                end
                @(posedge Clock);
                #1;
                out_ready = 1'b1;
            end
        join
        waitDrain("drain_bp");
        checkOutput("bp_pop_count", pops - pops_before, 3);

        $display("[TB] randomized traffic");
        stim_done = 1'b0;
        fork
            begin
                int a, b, op;
                for (int n = 0; n < 80; n++) begin
                    a  = int'($urandom_range(0, MSKW));
                    op = int'($urandom_range(0, 15));
                    b  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, MSKW));
                    if (n % 10 == 0) a = (n % 20 == 0) ? 0 : MSKW;
                    applyStimulus(a, b, op);
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge Clock);
                        #1;
                    end
                end
                stim_done = 1'b1;
            end
            begin
                while (!stim_done) begin
                    @(posedge Clock);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        waitDrain("drain_random");

        $display("[TB] reset during divide");
        applyStimulus(8'hC8, 8'h03, 15);
        repeat (3) @(posedge Clock);
        #1;
        Resetn = 1'b0;
        repeat (4) begin
            @(negedge Clock);
            checkOutput("rst_mid_out_valid", int'(out_valid), 0);
            checkOutput("rst_mid_result", int'(Result), 0);
            checkOutput("rst_mid_remainder", int'(Remainder), 0);
        end
        @(posedge Clock);
        #1;
        sb.delete();
        Resetn = 1'b1;
        @(negedge Clock);
        checkOutput("rst_mid_in_ready", int'(in_ready), 1);
        seen = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge Clock);
            if (out_valid) seen++;
        end
        checkOutput("rst_mid_stale_valid", seen, 0);
        @(posedge Clock);
        #1;
        applyStimulus(8'h64, 8'h07, 15);
        waitDrain("drain_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
